// File: rtl/dma_access_arbiter_pkg.sv
// Shared hw-mod memory map defaults and the DMA arbiter state encoding.
// Imported by the arbiter and by the other blocks that need the SMEM/KMEM map.
package dma_access_arbiter_pkg;

  localparam logic [15:0] SMEM_BASE_DEF = 16'hE000;
  localparam logic [15:0] SMEM_SIZE_DEF = 16'h1000;
  localparam logic [15:0] KMEM_BASE_DEF = 16'h6A00;
  localparam logic [15:0] KMEM_SIZE_DEF = 16'h0040;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // Inclusive last address of a region, widened to 17 bits so it cannot wrap.
  function automatic logic [16:0] region_last(input logic [15:0] base,
                                              input logic [15:0] size,
                                              input logic [16:0] trim);
    return {1'b0, base} + {1'b0, size} - trim;
  endfunction

endpackage

// File: rtl/dma_access_arbiter_addr_range_cmp.sv
// Inclusive address-range comparator: hit when BASE <= addr <= LAST.
// Bounds are 17 bits wide so a region ending at the top of memory does not wrap.
module addr_range_cmp #(
  parameter logic [16:0] BASE = 17'h00001,
  parameter logic [16:0] LAST = 17'h00001
) (
  input  logic [15:0] addr,
  output logic        hit
);

  logic [16:0] addr_ext;

  assign addr_ext = {1'b0, addr};
  assign hit      = (addr_ext >= BASE) && (addr_ext <= LAST);

endmodule

// File: rtl/dma_access_arbiter.sv
// Sequences DMA-master requests onto the core DMA port so that dma_en is never
// high while pc is in secure ROM; key-memory requests are refused outright.
module dma_access_arbiter
  import dma_access_arbiter_pkg::*;
#(
  parameter logic [15:0] SMEM_BASE = SMEM_BASE_DEF,
  parameter logic [15:0] SMEM_SIZE = SMEM_SIZE_DEF,
  parameter logic [15:0] KMEM_BASE = KMEM_BASE_DEF,
  parameter logic [15:0] KMEM_SIZE = KMEM_SIZE_DEF,
  parameter int          BURST_MAX = 8,
  parameter int          HOLD_MAX  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  input  logic        req_we,
  output logic        req_ready,
  output logic        req_err,
  output logic        dma_en,
  output logic [15:0] dma_addr,
  output logic        dma_we,
  input  logic        dma_ready
);

  localparam int HW = $clog2(HOLD_MAX);
  localparam int BW = $clog2(BURST_MAX);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_MAX - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

  // The last SMEM byte is excluded from the protected pc window.
  localparam logic [16:0] SMEM_LAST = region_last(SMEM_BASE, SMEM_SIZE, 17'd2);
  localparam logic [16:0] KMEM_LAST = region_last(KMEM_BASE, KMEM_SIZE, 17'd1);

  logic in_smem;
  logic in_kmem;

  addr_range_cmp #(.BASE({1'b0, SMEM_BASE}), .LAST(SMEM_LAST)) u_smem_cmp (
    .addr (pc),
    .hit  (in_smem)
  );

  addr_range_cmp #(.BASE({1'b0, KMEM_BASE}), .LAST(KMEM_LAST)) u_kmem_cmp (
    .addr (req_addr),
    .hit  (in_kmem)
  );

  state_e        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [15:0]   dma_addr_q, dma_addr_d;
  logic          dma_we_q, dma_we_d;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    burst_cnt_d = burst_cnt_q;
    dma_addr_d  = dma_addr_q;
    dma_we_d    = dma_we_q;
    req_ready   = 1'b0;
    req_err     = 1'b0;
    dma_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!req_valid) begin
          burst_cnt_d = '0;
        end else if (in_kmem) begin
          req_ready = 1'b1;
          req_err   = 1'b1;
        end else begin
          dma_addr_d = req_addr;
          dma_we_d   = req_we;
          if (in_smem) begin
            hold_cnt_d = '0;
            state_d    = ST_HOLD;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // Gating is combinational so pc entering SMEM kills dma_en that cycle.
        dma_en = ~in_smem;
        if (in_smem) begin
          hold_cnt_d = '0;
          state_d    = ST_HOLD;
        end else if (dma_ready) begin
          req_ready = 1'b1;
          if (burst_cnt_q == BURST_LAST) begin
            burst_cnt_d = '0;
            state_d     = ST_GAP;
          end else begin
            burst_cnt_d = burst_cnt_q + BW'(1);
            state_d     = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (!in_smem) begin
          state_d = ST_ISSUE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          req_ready = 1'b1;
          req_err   = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= '0;
      burst_cnt_q <= '0;
      dma_addr_q  <= '0;
      dma_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      dma_addr_q  <= dma_addr_d;
      dma_we_q    <= dma_we_d;
    end
  end

  assign dma_addr = dma_addr_q;
  assign dma_we   = dma_we_q;

endmodule

// File: tb/tb_dma_access_arbiter.sv
// Bench for dma_access_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a request-level reference model.
module tb_dma_access_arbiter;

  localparam int BURST_MAX = 8;
  localparam int HOLD_MAX  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_we;
  logic        req_ready;
  logic        req_err;
  logic        dma_en;
  logic [15:0] dma_addr;
  logic        dma_we;
  logic        dma_ready;

  always #5 clk = ~clk;

  dma_access_arbiter #(.BURST_MAX(BURST_MAX), .HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_ready (req_ready),
    .req_err   (req_err),
    .dma_en    (dma_en),
    .dma_addr  (dma_addr),
    .dma_we    (dma_we),
    .dma_ready (dma_ready)
  );

  int checks = 0;
  int fails  = 0;

  // Model: is a request captured, is it waiting on SMEM, how long, etc.
  bit          m_busy, m_wait_smem, m_gap;
  int          m_waited, m_done_in_burst;
  logic [15:0] m_addr;
  logic        m_we;
  bit          n_busy, n_wait_smem, n_gap;
  int          n_waited, n_done_in_burst;
  logic [15:0] n_addr;
  logic        n_we;
  bit          e_ready, e_err, e_en;
  bit          obs_ready, obs_err, obs_en;

  function automatic bit pc_secure(input logic [15:0] p);
    return int'(p) >= 'hE000 && int'(p) <= 'hE000 + 'h1000 - 2;
  endfunction

  function automatic bit addr_key(input logic [15:0] a);
    return int'(a) >= 'h6A00 && int'(a) <= 'h6A00 + 'h40 - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wait_smem = 0; m_gap = 0; m_waited = 0; m_done_in_burst = 0;
    m_addr = '0; m_we = 1'b0;
  endtask

  task automatic model_eval();
    bit sec;
    sec = pc_secure(pc);
    e_ready = 0; e_err = 0; e_en = 0;
    n_busy = m_busy; n_wait_smem = m_wait_smem; n_gap = 0; n_waited = m_waited;
    n_done_in_burst = m_done_in_burst; n_addr = m_addr; n_we = m_we;
    if (m_gap) begin
      // forced idle cycle after a full burst
    end else if (!m_busy) begin
      if (!req_valid) n_done_in_burst = 0;
      else if (addr_key(req_addr)) begin e_ready = 1; e_err = 1; end
      else begin
        n_busy = 1; n_wait_smem = sec; n_waited = 0; n_addr = req_addr; n_we = req_we;
      end
    end else if (m_wait_smem) begin
      if (!sec) n_wait_smem = 0;
      else if (m_waited == HOLD_MAX - 1) begin
        e_ready = 1; e_err = 1; n_busy = 0; n_wait_smem = 0;
      end else n_waited = m_waited + 1;
    end else begin
      e_en = !sec;
      if (sec) begin n_wait_smem = 1; n_waited = 0; end
      else if (dma_ready) begin
        e_ready = 1; n_busy = 0;
        if (m_done_in_burst + 1 == BURST_MAX) begin n_done_in_burst = 0; n_gap = 1; end
        else n_done_in_burst = m_done_in_burst + 1;
      end
    end
  endtask

  // One clock: inputs already driven; check at negedge, advance model at posedge.
  task automatic tick();
    @(negedge clk);
    obs_ready = req_ready; obs_err = req_err; obs_en = dma_en;
    if (!rst) begin
      model_eval();
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("req_err", 32'(req_err), 32'(e_err));
      chk("dma_en", 32'(dma_en), 32'(e_en));
      chk("dma_addr", 32'(dma_addr), 32'(m_addr));
      chk("dma_we", 32'(dma_we), 32'(m_we));
      chk("no_en_in_smem", 32'(dma_en & pc_secure(pc)), 32'd0);
    end
    @(posedge clk);
    if (rst) model_reset();
    else begin
      m_busy = n_busy; m_wait_smem = n_wait_smem; m_gap = n_gap; m_waited = n_waited;
      m_done_in_burst = n_done_in_burst; m_addr = n_addr; m_we = n_we;
    end
    #1;
  endtask

  initial begin
    int k;
    bit en_seen;
    model_reset();
    rst = 1'b1; pc = 16'h4000; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; dma_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_en", 32'(obs_en), 32'd0);
    chk("reset_addr", 32'(dma_addr), 32'd0);

    // Plain transfer outside SMEM
    dma_ready = 1'b1; req_valid = 1'b1; req_addr = 16'h0200; req_we = 1'b1;
    tick();
    chk("basic_accept_en", 32'(obs_en), 32'd0);
    tick();
    chk("basic_en", 32'(obs_en), 32'd1);
    chk("basic_ready", 32'(obs_ready), 32'd1);
    chk("basic_err", 32'(obs_err), 32'd0);
    chk("basic_addr", 32'(dma_addr), 32'h0200);
    req_valid = 1'b0; tick();

    // Key region refused immediately, even with pc in SMEM
    pc = 16'hE100; req_valid = 1'b1; req_addr = 16'h6A10; req_we = 1'b0;
    tick();
    chk("kmem_ready", 32'(obs_ready), 32'd1);
    chk("kmem_err", 32'(obs_err), 32'd1);
    chk("kmem_en", 32'(obs_en), 32'd0);
    req_valid = 1'b0; tick();

    // Held while pc in SMEM, issues the cycle after pc leaves
    req_valid = 1'b1; req_addr = 16'h0300; req_we = 1'b0;
    en_seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); en_seen |= obs_en; end
    chk("hold_no_en", 32'(en_seen), 32'd0);
    pc = 16'h4000;
    tick();
    chk("hold_exit_en0", 32'(obs_en), 32'd0);
    tick();
    chk("hold_exit_en1", 32'(obs_en), 32'd1);
    chk("hold_exit_ready", 32'(obs_ready), 32'd1);
    req_valid = 1'b0; tick();

    // Hold timeout
    pc = 16'hE002; req_valid = 1'b1; req_addr = 16'h0400;
    tick();
    k = 0; en_seen = 0;
    do begin tick(); k++; en_seen |= obs_en; end while (!obs_ready && k < 100);
    chk("timeout_cycles", 32'(k), 32'(HOLD_MAX));
    chk("timeout_err", 32'(obs_err), 32'd1);
    chk("timeout_no_en", 32'(en_seen), 32'd0);
    req_valid = 1'b0; tick();

    // Burst limiter: ninth back-to-back request waits one extra gap cycle
    pc = 16'h4000; dma_ready = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      req_addr = 16'h1000 + 16'(i);
      k = 0;
      do begin tick(); k++; end while (!obs_ready && k < 20);
      chk("burst_cycles", 32'(k), (i == 8) ? 32'd3 : 32'd2);
    end
    req_valid = 1'b0; tick();

    // pc jumps into SMEM mid-transfer
    dma_ready = 1'b0; req_valid = 1'b1; req_addr = 16'h0500; req_we = 1'b1;
    tick();
    tick();
    chk("jump_en_before", 32'(obs_en), 32'd1);
    pc = 16'hE000; dma_ready = 1'b1;
    tick();
    chk("jump_en_gated", 32'(obs_en), 32'd0);
    chk("jump_no_ready", 32'(obs_ready), 32'd0);
    pc = 16'h4000;
    tick();
    tick();
    chk("jump_complete", 32'(obs_ready), 32'd1);
    req_valid = 1'b0; tick();

    // Reset while holding
    pc = 16'hE100; req_valid = 1'b1; req_addr = 16'h0600; req_we = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = 1'b0;
    tick();
    chk("rst_hold_ready", 32'(obs_ready), 32'd0);
    chk("rst_hold_addr", 32'(dma_addr), 32'd0);
    chk("rst_hold_we", 32'(dma_we), 32'd0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      if (($urandom % 10) == 0) begin
        case ($urandom % 6)
          0: pc = 16'hE000;
          1: pc = 16'hEFFE;
          2: pc = 16'hEFFF;
          3: pc = 16'hDFFF;
          4: pc = 16'hE000 + 16'($urandom_range(0, 'hFFE));
          default: pc = 16'($urandom);
        endcase
      end
      dma_ready = 1'($urandom % 2);
      if (!req_valid && ($urandom % 3) == 0) begin
        req_valid = 1'b1;
        req_we    = 1'($urandom % 2);
        case ($urandom % 6)
          0: req_addr = 16'h69FF;
          1: req_addr = 16'h6A00;
          2: req_addr = 16'h6A3F;
          3: req_addr = 16'h6A40;
          default: req_addr = 16'($urandom);
        endcase
      end
      tick();
      if (e_ready) req_valid = 1'b0;
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
